// File: rtl/cdce62002_sequencer.sv
// Power-up, program, lock-qualify and retry sequencer in front of the CDCE62002 SPI programmer.
// All outputs registered; prog_send is withheld while prog_busy is high (a restart then waits in WAIT_BUSY_LO).
`timescale 1ns/1ps
module cdce62002_sequencer #(
  parameter int POWERUP_CYCLES = 4000000,
  parameter int BUSY_TIMEOUT   = 64,
  parameter int LOCK_TIMEOUT   = 400000,
  parameter int LOCK_STABLE    = 4096,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       prog_busy,
  input  logic       pll_lock_async,
  output logic       prog_send,
  output logic       clock_ready,
  output logic       clock_failed,
  output logic [1:0] attempt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] ST_POWERUP      = 3'd0;
  localparam logic [2:0] ST_SEND         = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY_LO = 3'd3;
  localparam logic [2:0] ST_LOCK_WAIT    = 3'd4;
  localparam logic [2:0] ST_LOCKED       = 3'd5;
  localparam logic [2:0] ST_RETRY        = 3'd6;
  localparam logic [2:0] ST_FAILED       = 3'd7;

  localparam int              ST_W    = $clog2(LOCK_STABLE) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ST_W-1:0]  STB_MAX = {ST_W{1'b1}};
  localparam logic [1:0]       ATT_MAX = 2'(MAX_RETRIES);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [ST_W-1:0]  stable;
  logic             lock_meta;
  logic             lock_s;
  logic             resend_pending;
  logic             take_restart;
  logic             enter;

  assign take_restart = restart && (state != ST_POWERUP);
  assign enter        = (next_state != state) || take_restart;
  assign state_dbg    = state;

  always_comb begin
    next_state = state;
    case (state)
      ST_POWERUP:
        if (cnt == CNT_W'(POWERUP_CYCLES - 1)) next_state = ST_SEND;
      ST_SEND:
        next_state = ST_WAIT_BUSY_HI;
      ST_WAIT_BUSY_HI:
        if (prog_busy) next_state = ST_WAIT_BUSY_LO;
        else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) next_state = ST_RETRY;
      ST_WAIT_BUSY_LO:
        if (!prog_busy) next_state = resend_pending ? ST_SEND : ST_LOCK_WAIT;
      ST_LOCK_WAIT:
        if (lock_s && (stable == ST_W'(LOCK_STABLE - 1))) next_state = ST_LOCKED;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) next_state = ST_RETRY;
      ST_LOCKED:
        if (!lock_s) next_state = ST_RETRY;
      ST_RETRY:
        next_state = (attempt == ATT_MAX) ? ST_FAILED : ST_SEND;
      default:
        next_state = ST_FAILED;
    endcase
    // A restart during an in-flight transfer parks in WAIT_BUSY_LO and sends once busy drops.
    if (take_restart) next_state = prog_busy ? ST_WAIT_BUSY_LO : ST_SEND;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_POWERUP;
      cnt            <= '0;
      stable         <= '0;
      lock_meta      <= 1'b0;
      lock_s         <= 1'b0;
      resend_pending <= 1'b0;
      prog_send      <= 1'b0;
      clock_ready    <= 1'b0;
      clock_failed   <= 1'b0;
      attempt        <= 2'd0;
    end else begin
      state     <= next_state;
      lock_meta <= pll_lock_async;
      lock_s    <= lock_meta;

      if (enter) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (enter || !lock_s || (state != ST_LOCK_WAIT)) stable <= '0;
      else if (stable != STB_MAX) stable <= stable + 1'b1;

      if (take_restart) resend_pending <= prog_busy;
      else if ((state == ST_WAIT_BUSY_LO) && !prog_busy) resend_pending <= 1'b0;

      prog_send   <= (next_state == ST_SEND);
      clock_ready <= (state == ST_LOCKED) && (next_state == ST_LOCKED);

      if (take_restart) clock_failed <= 1'b0;
      else if (next_state == ST_FAILED) clock_failed <= 1'b1;

      if (take_restart) attempt <= 2'd0;
      else if ((state == ST_RETRY) && (attempt != ATT_MAX)) attempt <= attempt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdce62002_sequencer.sv
// Scoreboarded bench for cdce62002_sequencer with a cycle-driven programmer and PLL_LOCK model.
`timescale 1ns/1ps
module tb_cdce62002_sequencer;

  localparam int NEVER = 1 << 30;

  logic       clk;
  logic       reset;
  logic       restart;
  logic       prog_busy;
  logic       pll_lock_async;
  logic       prog_send;
  logic       clock_ready;
  logic       clock_failed;
  logic [1:0] attempt;
  logic [2:0] state_dbg;

  cdce62002_sequencer #(
    .POWERUP_CYCLES(16),
    .BUSY_TIMEOUT  (8),
    .LOCK_TIMEOUT  (100),
    .LOCK_STABLE   (8),
    .MAX_RETRIES   (2),
    .CNT_W         (23)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .restart       (restart),
    .prog_busy     (prog_busy),
    .pll_lock_async(pll_lock_async),
    .prog_send     (prog_send),
    .clock_ready   (clock_ready),
    .clock_failed  (clock_failed),
    .attempt       (attempt),
    .state_dbg     (state_dbg)
  );

  typedef struct {
    int         cyc;
    logic [1:0] att;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc;
  int  n_pulse;
  bit  prog_en;
  bit  glitch;
  int  lock_after;
  int  lock_rise;
  int  drop_cyc;
  int  busy_start;
  int  busy_end;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // One clock: sample just after the edge, score prog_send pulses, then update the programmer and lock-pin models.
  task automatic tick();
    ev_t e;
    bit  nb;
    @(posedge clk);
    #1;
    cyc++;
    if (prog_send) begin
      n_pulse++;
      n_vec++;
      if (prog_busy !== 1'b0) begin
        n_err++;
        $display("FAIL send_while_busy: cycle %0d prog_busy=%b, required 0", cyc, prog_busy);
      end
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_send: pulse at cycle %0d attempt=%0d, required no pulse", cyc, attempt);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || attempt !== e.att) begin
          n_err++;
          $display("FAIL send_event: cycle %0d attempt %0d, required cycle %0d attempt %0d",
                   cyc, attempt, e.cyc, e.att);
        end
      end
      if (prog_en) begin
        busy_start = cyc + 1;
        busy_end   = cyc + 51;
      end
    end
    nb = prog_en && (cyc >= busy_start) && (cyc < busy_end);
    if (prog_busy && !nb && (lock_after >= 0) && (lock_rise == NEVER)) lock_rise = cyc + lock_after;
    prog_busy      = nb;
    pll_lock_async = (cyc >= lock_rise) && !(glitch && (cyc == lock_rise + 5)) && (cyc != drop_cyc);
  endtask

  task automatic run_to(input int target, input string name);
    if (target > cyc + 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: target cycle %0d unreachable from %0d, required event within budget", name, target, cyc);
      return;
    end
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    restart        = 1'b0;
    prog_en        = 1'b0;
    glitch         = 1'b0;
    lock_after     = -1;
    lock_rise      = NEVER;
    drop_cyc       = -1;
    busy_start     = 0;
    busy_end       = 0;
    prog_busy      = 1'b0;
    pll_lock_async = 1'b0;
    repeat (3) tick();
    reset   = 1'b0;
    cyc     = 0;
    n_pulse = 0;
    sb.delete();
  endtask

  task automatic check_sb_empty(input string name);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected pulses outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({prog_send, clock_ready, clock_failed, attempt, state_dbg} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_values: send=%b ready=%b failed=%b attempt=%0d state=%0d, required all 0",
               prog_send, clock_ready, clock_failed, attempt, state_dbg);
    end
    sb.push_back('{16, 2'd0});
    run_to(15, "powerup_wait");
    n_vec++;
    if (state_dbg !== 3'd0 || n_pulse != 0) begin
      n_err++;
      $display("FAIL powerup_hold: state=%0d pulses=%0d at cycle 15, required state 0 pulses 0", state_dbg, n_pulse);
    end
    tick();
    n_vec++;
    if (state_dbg !== 3'd1) begin
      n_err++;
      $display("FAIL powerup_exit: state=%0d at cycle 16, required 1", state_dbg);
    end
    check_sb_empty("reset_sb");
  endtask

  task automatic test_nominal();
    do_reset();
    prog_en    = 1'b1;
    lock_after = 20;
    sb.push_back('{16, 2'd0});
    run_to(80, "nominal_busy");
    run_to(lock_rise + 10, "nominal_lock");
    n_vec++;
    if (clock_ready !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_ready_early: ready=%b at rise+10, required 0", clock_ready);
    end
    tick();
    n_vec++;
    if (clock_ready !== 1'b1 || attempt !== 2'd0 || state_dbg !== 3'd5) begin
      n_err++;
      $display("FAIL nominal_ready: ready=%b attempt=%0d state=%0d at rise+11, required 1/0/5",
               clock_ready, attempt, state_dbg);
    end
    check_sb_empty("nominal_sb");
  endtask

  task automatic test_loss_of_lock();
    int d;
    d        = cyc + 5;
    drop_cyc = d;
    sb.push_back('{d + 4, 2'd1});
    run_to(d + 2, "loss_pre");
    n_vec++;
    if (clock_ready !== 1'b1) begin
      n_err++;
      $display("FAIL loss_ready_hold: ready=%b at drop+2, required 1", clock_ready);
    end
    tick();
    n_vec++;
    if (clock_ready !== 1'b0 || state_dbg !== 3'd6 || attempt !== 2'd0) begin
      n_err++;
      $display("FAIL loss_ready_fall: ready=%b state=%0d attempt=%0d at drop+3, required 0/6/0",
               clock_ready, state_dbg, attempt);
    end
    tick();
    n_vec++;
    if (attempt !== 2'd1) begin
      n_err++;
      $display("FAIL loss_attempt: attempt=%0d, required 1", attempt);
    end
    check_sb_empty("loss_sb");
  endtask

  task automatic test_glitch();
    do_reset();
    prog_en    = 1'b1;
    lock_after = 20;
    glitch     = 1'b1;
    sb.push_back('{16, 2'd0});
    run_to(80, "glitch_busy");
    run_to(lock_rise + 16, "glitch_lock");
    n_vec++;
    if (clock_ready !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_ready_early: ready=%b at final_rise+10, required 0", clock_ready);
    end
    tick();
    n_vec++;
    if (clock_ready !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_ready: ready=%b at final_rise+11, required 1", clock_ready);
    end
    check_sb_empty("glitch_sb");
  endtask

  task automatic test_exhaustion();
    do_reset();
    prog_en = 1'b1;
    sb.push_back('{16, 2'd0});
    sb.push_back('{169, 2'd1});
    sb.push_back('{322, 2'd2});
    run_to(474, "exhaust_retry");
    n_vec++;
    if (state_dbg !== 3'd6 || clock_failed !== 1'b0) begin
      n_err++;
      $display("FAIL exhaust_last_retry: state=%0d failed=%b at 474, required 6/0", state_dbg, clock_failed);
    end
    tick();
    n_vec++;
    if (state_dbg !== 3'd7 || clock_failed !== 1'b1 || attempt !== 2'd2 || clock_ready !== 1'b0) begin
      n_err++;
      $display("FAIL exhaust_failed: state=%0d failed=%b attempt=%0d ready=%b, required 7/1/2/0",
               state_dbg, clock_failed, attempt, clock_ready);
    end
    run_to(1475, "exhaust_idle");
    n_vec++;
    if (n_pulse != 3 || state_dbg !== 3'd7 || clock_failed !== 1'b1) begin
      n_err++;
      $display("FAIL exhaust_quiet: pulses=%0d state=%0d failed=%b, required 3/7/1", n_pulse, state_dbg, clock_failed);
    end
    check_sb_empty("exhaust_sb");
  endtask

  task automatic test_failed_restart();
    sb.push_back('{cyc + 1, 2'd0});
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_vec++;
    if (clock_failed !== 1'b0 || attempt !== 2'd0 || state_dbg !== 3'd1) begin
      n_err++;
      $display("FAIL failed_restart: failed=%b attempt=%0d state=%0d, required 0/0/1", clock_failed, attempt, state_dbg);
    end
    check_sb_empty("failed_restart_sb");
  endtask

  task automatic test_busy_timeout();
    do_reset();
    sb.push_back('{16, 2'd0});
    sb.push_back('{26, 2'd1});
    sb.push_back('{36, 2'd2});
    run_to(25, "busy_to_first");
    n_vec++;
    if (state_dbg !== 3'd6) begin
      n_err++;
      $display("FAIL busy_timeout_retry: state=%0d at 25, required 6", state_dbg);
    end
    run_to(45, "busy_to_last");
    n_vec++;
    if (state_dbg !== 3'd6 || clock_failed !== 1'b0) begin
      n_err++;
      $display("FAIL busy_timeout_last: state=%0d failed=%b at 45, required 6/0", state_dbg, clock_failed);
    end
    tick();
    n_vec++;
    if (state_dbg !== 3'd7 || clock_failed !== 1'b1) begin
      n_err++;
      $display("FAIL busy_timeout_failed: state=%0d failed=%b at 46, required 7/1", state_dbg, clock_failed);
    end
    run_to(100, "busy_to_idle");
    n_vec++;
    if (n_pulse != 3) begin
      n_err++;
      $display("FAIL busy_timeout_pulses: %0d pulses, required 3", n_pulse);
    end
    check_sb_empty("busy_timeout_sb");
  endtask

  task automatic test_restart_busy();
    do_reset();
    prog_en = 1'b1;
    sb.push_back('{16, 2'd0});
    run_to(30, "restart_busy_pre");
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_vec++;
    if (state_dbg !== 3'd3 || prog_send !== 1'b0 || attempt !== 2'd0) begin
      n_err++;
      $display("FAIL restart_busy_park: state=%0d send=%b attempt=%0d, required 3/0/0", state_dbg, prog_send, attempt);
    end
    sb.push_back('{68, 2'd0});
    run_to(75, "restart_busy_post");
    n_vec++;
    if (n_pulse != 2) begin
      n_err++;
      $display("FAIL restart_busy_pulses: %0d pulses, required 2", n_pulse);
    end
    check_sb_empty("restart_busy_sb");
  endtask

  task automatic test_reset_mid();
    bit hit;
    do_reset();
    prog_en = 1'b1;
    sb.push_back('{16, 2'd0});
    sb.push_back('{169, 2'd1});
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      hit = (state_dbg == 3'd4) && (attempt == 2'd1);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid_reach: state=%0d attempt=%0d, required LOCK_WAIT with attempt 1", state_dbg, attempt);
    end
    check_sb_empty("reset_mid_sb");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({prog_send, clock_ready, clock_failed, attempt, state_dbg} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_mid_values: send=%b ready=%b failed=%b attempt=%0d state=%0d, required all 0",
               prog_send, clock_ready, clock_failed, attempt, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_loss_of_lock();
    test_glitch();
    test_exhaustion();
    test_failed_restart();
    test_busy_timeout();
    test_restart_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
